// File: rtl/reg_file_access_ctrl_if.sv
// Bus bundle between the register-file access controller and its neighbours.
// Carries the start/status pair, the register-file ports and the dump/load streams.
// master = controller side; slave = register file plus debug/test bus side.
interface reg_file_access_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // operation control and status
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  // register file read ports (data is registered, one cycle after address)
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_dat1;
  logic [DW-1:0] rd_dat2;
  // register file write port
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_dat;
  logic          wr_en;
  // dump stream out
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
  logic [AW-1:0] out_idx;
  // load stream in
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_dat;

  modport master (
    input  start, mode, rd_dat1, rd_dat2, out_rdy, in_vld, in_dat,
    output busy, done, rd_addr1, rd_addr2, wr_idx, wr_dat, wr_en,
           out_vld, out_dat, out_idx, in_rdy
  );

  modport slave (
    output start, mode, rd_dat1, rd_dat2, out_rdy, in_vld, in_dat,
    input  busy, done, rd_addr1, rd_addr2, wr_idx, wr_dat, wr_en,
           out_vld, out_dat, out_idx, in_rdy
  );
endinterface

// File: rtl/reg_file_access_ctrl.sv
// Walks the register file: dump streams (index, value) pairs out, load writes a word stream to 0..NREGS-1.
// Latency: dump 4 cycles per register pair minimum; load writes one cycle after each accepted word.
// Backpressure: dump holds out_dat/out_idx stable while out_rdy is low; load accepts one word per cycle.
module reg_file_access_ctrl #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  reg_file_access_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_LATCH,
    S_EMIT0,
    S_EMIT1,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] rd_addr1_q, rd_addr1_d;
  logic [AW-1:0] rd_addr2_q, rd_addr2_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [DW-1:0] wr_dat_q, wr_dat_d;
  logic          wr_en_q, wr_en_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_dat_q, out_dat_d;
  logic [AW-1:0] out_idx_q, out_idx_d;

  logic          out_hs;
  logic          in_hs;

  // out_vld_q is only ever high in the EMIT states, so it qualifies the dump handshake
  assign out_hs = out_vld_q && bus.out_rdy;
  assign in_hs  = (state_q == S_LOAD) && bus.in_vld;

  // State, walk index, pair buffers and every registered output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      wr_idx_q   <= '0;
      wr_dat_q   <= '0;
      wr_en_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      wr_idx_q   <= wr_idx_d;
      wr_dat_q   <= wr_dat_d;
      wr_en_q    <= wr_en_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_idx_q  <= out_idx_d;
    end
  end

  // Next state, index advance and capture of the read pair
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d     = '0;
          state_d = bus.mode ? S_LOAD : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_LATCH;
      S_RD_LATCH: begin
        buf0_d  = bus.rd_dat1;
        buf1_d  = bus.rd_dat2;
        state_d = S_EMIT0;
      end
      S_EMIT0: begin
        if (out_hs) state_d = S_EMIT1;
      end
      S_EMIT1: begin
        if (out_hs) begin
          if ((k_q + AW'(1)) == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + AW'(2);
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          if (k_q == LAST_IDX) state_d = S_DONE;
          else                 k_d = k_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rd_addr1_d = '0;
    rd_addr2_d = '0;
    out_vld_d  = 1'b0;
    out_dat_d  = '0;
    out_idx_d  = '0;
    if (state_d == S_RD_ISSUE) begin
      rd_addr1_d = k_d;
      rd_addr2_d = k_d + AW'(1);
    end
    if (state_d == S_EMIT0) begin
      out_vld_d = 1'b1;
      out_dat_d = buf0_d;
      out_idx_d = k_d;
    end
    if (state_d == S_EMIT1) begin
      out_vld_d = 1'b1;
      out_dat_d = buf1_d;
      out_idx_d = k_d + AW'(1);
    end
    // an accepted load word becomes a write in the following cycle
    wr_en_d  = in_hs;
    wr_idx_d = in_hs ? k_q : '0;
    wr_dat_d = in_hs ? bus.in_dat : '0;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_addr1 = rd_addr1_q;
  assign bus.rd_addr2 = rd_addr2_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_dat   = wr_dat_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_dat  = out_dat_q;
  assign bus.out_idx  = out_idx_q;
  assign bus.in_rdy   = (state_q == S_LOAD);

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Directed bench for reg_file_access_ctrl with a behavioural register file.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task checks its own results inline.
module tb_reg_file_access_ctrl;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  reg_file_access_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // behavioural register file: registered reads, write on wr_en
  logic [DW-1:0] rf [NREGS];
  logic          rf_init = 1'b0;
  always @(posedge clk) begin
    bus.rd_dat1 <= rf[bus.rd_addr1];
    bus.rd_dat2 <= rf[bus.rd_addr2];
    if (rf_init) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= (i == 23) ? 32'd16 : 32'(i);
    end else if (bus.wr_en) begin
      rf[bus.wr_idx] <= bus.wr_dat;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_rf [NREGS];

  // results collected by the stimulus runners
  logic [AW-1:0] got_idx [64];
  logic [DW-1:0] got_dat [64];
  logic [AW-1:0] wr_idx_log [64];
  logic [DW-1:0] wr_dat_log [64];
  bit            bz [256];
  int n_hs, n_done, n_wr, stall_viol, last_hs, done_cyc, first_wr, last_wr;

  task automatic run_dump(input bit stall_pat, input bit inject_start);
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    bit pend;
    pend = 0; pd = '0; pi = '0;
    n_hs = 0; n_done = 0; n_wr = 0; stall_viol = 0; last_hs = -1; done_cyc = -1;
    for (int i = 0; i < 64; i++) begin got_idx[i] = '1; got_dat[i] = '1; end
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.out_rdy = stall_pat ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      bus.start   = inject_start && bus.out_vld && (bus.out_idx == 5'd6);
      bus.mode    = bus.start;
      if (pend && (bus.out_vld !== 1'b1 || bus.out_dat !== pd || bus.out_idx !== pi)) stall_viol++;
      if (bus.wr_en) n_wr++;
      if (bus.done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (bus.out_vld && bus.out_rdy) begin
        if (n_hs < 64) begin got_idx[n_hs] = bus.out_idx; got_dat[n_hs] = bus.out_dat; end
        n_hs++; last_hs = c; pend = 0;
      end else if (bus.out_vld) begin
        pend = 1; pd = bus.out_dat; pi = bus.out_idx;
      end else begin
        pend = 0;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.mode = 1'b0; bus.out_rdy = 1'b0;
  endtask

  task automatic run_load(input bit gapped);
    int w;
    w = 0; n_wr = 0; n_done = 0; done_cyc = -1; first_wr = -1; last_wr = -1;
    for (int i = 0; i < 256; i++) bz[i] = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.mode = 1'b0;
    for (int c = 0; c < 256; c++) begin
      bz[c] = bus.busy;
      if (bus.wr_en) begin
        if (n_wr < 64) begin wr_idx_log[n_wr] = bus.wr_idx; wr_dat_log[n_wr] = bus.wr_dat; end
        n_wr++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (bus.done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      bus.in_vld = (w < NREGS) && (!gapped || (c % 3) != 2);
      bus.in_dat = 32'hA5A5_0000 + 32'(w);
      if (bus.in_vld && bus.in_rdy) w++;
      if ((done_cyc >= 0 && c >= done_cyc + 3) || c > 250) break;
      @(negedge clk);
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rf_init = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.out_rdy = 1'b0; bus.in_vld = 1'b0; bus.in_dat = '0;
    for (int i = 0; i < NREGS; i++) exp_rf[i] = (i == 23) ? 32'd16 : 32'(i);
    repeat (2) @(negedge clk);
    rf_init = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    n_checks++; if (bus.out_vld !== 1'b0 || bus.wr_en !== 1'b0 || bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: out_vld=%0b wr_en=%0b in_rdy=%0b want 0", bus.out_vld, bus.wr_en, bus.in_rdy); end
    n_checks++; if ({bus.rd_addr1, bus.rd_addr2, bus.wr_idx, bus.out_idx} !== 20'd0 ||
                    {bus.wr_dat, bus.out_dat} !== 64'd0) begin
      n_fail++; $display("FAIL reset_buses: got rd1=%0d rd2=%0d wi=%0d oi=%0d wd=%h od=%h want 0",
        bus.rd_addr1, bus.rd_addr2, bus.wr_idx, bus.out_idx, bus.wr_dat, bus.out_dat); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_dump_ready();
    int bad;
    run_dump(1'b0, 1'b0);
    n_checks++; if (n_hs != 32) begin n_fail++; $display("FAIL dump_count: got %0d want 32", n_hs); end
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (got_idx[i] !== AW'(i) || got_dat[i] !== exp_rf[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL dump_seq: got %0d bad words want 0", bad); end
    n_checks++; if (got_dat[23] !== 32'd16) begin n_fail++; $display("FAIL dump_r23: got %0d want 16", got_dat[23]); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL dump_done_count: got %0d want 1", n_done); end
    n_checks++; if (done_cyc - last_hs != 1) begin n_fail++; $display("FAIL dump_done_timing: got %0d cycles after last handshake want 1", done_cyc - last_hs); end
    n_checks++; if (n_wr != 0) begin n_fail++; $display("FAIL dump_no_write: got %0d writes want 0", n_wr); end
  endtask

  task automatic test_dump_stall();
    int bad;
    run_dump(1'b1, 1'b0);
    n_checks++; if (n_hs != 32) begin n_fail++; $display("FAIL stall_count: got %0d want 32", n_hs); end
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (got_idx[i] !== AW'(i) || got_dat[i] !== exp_rf[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_seq: got %0d bad words want 0", bad); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes during stall want 0", stall_viol); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", n_done); end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_dump(1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (got_idx[i] !== AW'(i) || got_dat[i] !== exp_rf[i]) bad++;
    n_checks++; if (n_hs != 32 || bad != 0) begin n_fail++; $display("FAIL busy_start_seq: got %0d words %0d bad want 32 and 0", n_hs, bad); end
    n_checks++; if (n_wr != 0) begin n_fail++; $display("FAIL busy_start_write: got %0d writes want 0", n_wr); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    int bad;
    found = 0;
    @(negedge clk); bus.start = 1'b1; bus.mode = 1'b0; bus.out_rdy = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.out_vld && bus.out_idx == 5'd10) begin found = 1; bus.out_rdy = 1'b0; break; end
      @(negedge clk);
    end
    n_checks++; if (!found || bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_reach: found=%0b busy=%0b want 1 1", found, bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.busy, bus.out_vld, bus.wr_en, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_async: busy/out_vld/wr_en/done got %b want 0000",
        {bus.busy, bus.out_vld, bus.wr_en, bus.done}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_dump(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (got_idx[i] !== AW'(i) || got_dat[i] !== exp_rf[i]) bad++;
    n_checks++; if (got_idx[0] !== 5'd0 || n_hs != 32 || bad != 0) begin
      n_fail++; $display("FAIL midreset_restart: first idx %0d words %0d bad %0d want 0 32 0", got_idx[0], n_hs, bad); end
  endtask

  task automatic test_load_gapped();
    int bad;
    run_load(1'b1);
    n_checks++; if (n_wr != 32) begin n_fail++; $display("FAIL load_count: got %0d writes want 32", n_wr); end
    bad = 0;
    for (int i = 0; i < NREGS; i++)
      if (wr_idx_log[i] !== AW'(i) || wr_dat_log[i] !== (32'hA5A5_0000 + 32'(i))) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL load_seq: got %0d bad writes want 0", bad); end
    n_checks++; if (n_done != 1 || done_cyc != last_wr) begin
      n_fail++; $display("FAIL load_done: count %0d at cycle %0d want 1 at last write cycle %0d", n_done, done_cyc, last_wr); end
    for (int i = 0; i < NREGS; i++) exp_rf[i] = 32'hA5A5_0000 + 32'(i);
    run_dump(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (got_idx[i] !== AW'(i) || got_dat[i] !== exp_rf[i]) bad++;
    n_checks++; if (n_hs != 32 || bad != 0) begin n_fail++; $display("FAIL load_readback: got %0d words %0d bad want 32 0", n_hs, bad); end
  endtask

  task automatic test_load_full_rate();
    run_load(1'b0);
    // words accepted on cycles 0..31 are written on cycles 1..32; DONE shares cycle 32
    n_checks++; if (n_wr != 32 || first_wr != 1 || last_wr != 32) begin
      n_fail++; $display("FAIL full_rate_writes: got %0d writes cycles %0d..%0d want 32 cycles 1..32", n_wr, first_wr, last_wr); end
    n_checks++; if (last_wr < 0 || last_wr > 250 || bz[last_wr] !== 1'b1 || bz[last_wr + 1] !== 1'b0) begin
      n_fail++; $display("FAIL full_rate_busy: busy after last write not 1 then 0 (last_wr=%0d)", last_wr); end
    n_checks++; if (n_done != 1 || done_cyc != 32) begin n_fail++; $display("FAIL full_rate_done: count %0d cycle %0d want 1 at 32", n_done, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_dump_ready();
    test_dump_stall();
    test_start_ignored();
    test_reset_mid_dump();
    test_load_gapped();
    test_load_full_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
